// File: rtl/usb_tx_pkg.sv
// Shared constants for the USB transmit path: encoder packet codes, payload
// widths, winner indices and the tx arbiter state encoding.
package usb_tx_pkg;

  localparam logic [1:0] PKT_NONE   = 2'b00;
  localparam logic [1:0] PKT_TOKEN  = 2'b01;
  localparam logic [1:0] PKT_HSHAKE = 2'b10;
  localparam logic [1:0] PKT_DATA   = 2'b11;

  localparam int DATA_W = 72;
  localparam int TOK_W  = 19;
  localparam int HS_W   = 8;

  // Bit positions inside the one-hot winner vector.
  localparam int WIN_HS  = 0;
  localparam int WIN_TOK = 1;
  localparam int WIN_DAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } tx_arb_state_t;

  function automatic logic [1:0] win_code(input logic [2:0] win);
    logic [1:0] code;
    code = PKT_NONE;
    if (win[WIN_HS])       code = PKT_HSHAKE;
    else if (win[WIN_TOK]) code = PKT_TOKEN;
    else if (win[WIN_DAT]) code = PKT_DATA;
    return code;
  endfunction

endpackage

// File: rtl/tx_arb_pick.sv
// Combinational winner select: handshake first, then token before data unless
// the starvation flag promotes data above token.
module tx_arb_pick
  import usb_tx_pkg::*;
(
  input  logic       hs_req,
  input  logic       tok_req,
  input  logic       dat_req,
  input  logic       starve,
  output logic [2:0] win
);

  always_comb begin
    win = 3'b000;
    if (hs_req)                 win[WIN_HS]  = 1'b1;
    else if (starve && dat_req) win[WIN_DAT] = 1'b1;
    else if (tok_req)           win[WIN_TOK] = 1'b1;
    else if (dat_req)           win[WIN_DAT] = 1'b1;
  end

endmodule

// File: rtl/tx_pkt_arbiter.sv
// Shares the serial packet encoder among handshake, token and data sources.
// Define TX_ARB_STARVE_EN to let data overtake token after repeated token wins.
module tx_pkt_arbiter
  import usb_tx_pkg::*;
#(
  parameter int DATA_STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs_req,
  input  logic [7:0]  hs_pid,
  output logic        hs_gnt,
  output logic        hs_done,
  input  logic        tok_req,
  input  logic [18:0] tok_bits,
  output logic        tok_gnt,
  output logic        tok_done,
  input  logic        dat_req,
  input  logic [71:0] dat_bits,
  output logic        dat_gnt,
  output logic        dat_done,
  input  logic        free_inbound,
  output logic [1:0]  pkt_type,
  output logic [71:0] data,
  output logic [18:0] token,
  output logic [7:0]  hshake,
  output logic        busy
);

  tx_arb_state_t     state_q, state_d;
  logic [2:0]        win_q, win_d;
  logic [1:0]        pkt_type_q, pkt_type_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TOK_W-1:0]  token_q, token_d;
  logic [HS_W-1:0]   hshake_q, hshake_d;
  logic              busy_q, busy_d;
  logic [2:0]        pick, gnt, done;
  logic              fire, starve;

  assign fire = (state_q == ST_IDLE) && free_inbound;

`ifdef TX_ARB_STARVE_EN
  localparam int CW = $clog2(DATA_STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DATA_STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  assign starve = (starve_cnt_q == LIMIT);

  // Only token wins that actually bypass waiting data count as starvation.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fire && pick[WIN_DAT])
      starve_cnt_d = '0;
    else if (fire && pick[WIN_TOK] && dat_req && (starve_cnt_q != LIMIT))
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`else
  // Strict priority: the limit has no meaning, and a negative limit never occurs.
  assign starve = (DATA_STARVE_LIMIT < 0);
`endif

  tx_arb_pick u_pick (
    .hs_req (hs_req),
    .tok_req(tok_req),
    .dat_req(dat_req),
    .starve (starve),
    .win    (pick)
  );

  assign gnt  = fire ? pick : 3'b000;
  assign done = ((state_q == ST_BUSY) && free_inbound) ? win_q : 3'b000;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    pkt_type_d = PKT_NONE;
    data_d     = data_q;
    token_d    = token_q;
    hshake_d   = hshake_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (fire && (pick != 3'b000)) begin
          state_d    = ST_ISSUE;
          win_d      = pick;
          pkt_type_d = win_code(pick);
          busy_d     = 1'b1;
          if (pick[WIN_HS])  hshake_d = hs_pid;
          if (pick[WIN_TOK]) token_d  = tok_bits;
          if (pick[WIN_DAT]) data_d   = dat_bits;
        end
      end
      ST_ISSUE: state_d = ST_BUSY;
      ST_BUSY: begin
        if (free_inbound) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win_q      <= 3'b000;
      pkt_type_q <= PKT_NONE;
      data_q     <= '0;
      token_q    <= '0;
      hshake_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      pkt_type_q <= pkt_type_d;
      data_q     <= data_d;
      token_q    <= token_d;
      hshake_q   <= hshake_d;
      busy_q     <= busy_d;
    end
  end

  assign hs_gnt   = gnt[WIN_HS];
  assign tok_gnt  = gnt[WIN_TOK];
  assign dat_gnt  = gnt[WIN_DAT];
  assign hs_done  = done[WIN_HS];
  assign tok_done = done[WIN_TOK];
  assign dat_done = done[WIN_DAT];
  assign pkt_type = pkt_type_q;
  assign data     = data_q;
  assign token    = token_q;
  assign hshake   = hshake_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Scoreboard bench for tx_pkt_arbiter: expected grants are queued as stimulus
// is driven and matched against grants, packet strobes and payloads.
module tb_tx_pkt_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs_req, tok_req, dat_req, free_inbound;
  logic [7:0]  hs_pid;
  logic [18:0] tok_bits;
  logic [71:0] dat_bits;
  logic        hs_gnt, hs_done, tok_gnt, tok_done, dat_gnt, dat_done;
  logic [1:0]  pkt_type;
  logic [71:0] data;
  logic [18:0] token;
  logic [7:0]  hshake;
  logic        busy;

  tx_pkt_arbiter #(.DATA_STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .hs_req(hs_req), .hs_pid(hs_pid), .hs_gnt(hs_gnt), .hs_done(hs_done),
    .tok_req(tok_req), .tok_bits(tok_bits), .tok_gnt(tok_gnt), .tok_done(tok_done),
    .dat_req(dat_req), .dat_bits(dat_bits), .dat_gnt(dat_gnt), .dat_done(dat_done),
    .free_inbound(free_inbound), .pkt_type(pkt_type),
    .data(data), .token(token), .hshake(hshake), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  code;
    logic [71:0] pay;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  bit   issue_chk = 1'b0;
  logic [2:0] last_win = 3'b000;

  localparam logic [2:0] M_HS = 3'b001, M_TOK = 3'b010, M_DAT = 3'b100;
  localparam logic [18:0] TOKV = 19'h25A5A;
  localparam logic [71:0] DATV = 72'hDE_ADBE_EF01_2345_6789;

  // Scoreboard monitor: every grant pops an expectation, the next cycle must
  // carry its packet code and payload, and any done must name the last winner.
  always @(negedge clk) begin
    logic [2:0] g, d;
    logic [1:0] gc;
    logic [71:0] pv;
    g = {dat_gnt, tok_gnt, hs_gnt};
    d = {dat_done, tok_done, hs_done};
    if (!rst_n) begin
      issue_chk = 1'b0;
    end else begin
      checks++;
      if ($countones(g) > 1 || $countones(d) > 1) begin
        errors++; $display("FAIL onehot: gnt=%b done=%b required at most one each", g, d);
      end
      checks++;
      if (issue_chk) begin
        pv = (cur.code == 2'b01) ? {53'd0, token} :
             (cur.code == 2'b10) ? {64'd0, hshake} : data;
        if (pkt_type !== cur.code || pv !== cur.pay) begin
          errors++;
          $display("FAIL issue: pkt_type=%b payload=%h required %b %h", pkt_type, pv, cur.code, cur.pay);
        end
        issue_chk = 1'b0;
      end else if (pkt_type !== 2'b00) begin
        errors++; $display("FAIL pkt_idle: pkt_type=%b required 00", pkt_type);
      end
      if (d != 3'b000) begin
        checks++;
        if (d !== last_win) begin
          errors++; $display("FAIL done_owner: done=%b required %b", d, last_win);
        end
      end
      if (g != 3'b000) begin
        gc = g[0] ? 2'b10 : (g[1] ? 2'b01 : 2'b11);
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL sb_empty: unexpected grant %b", g);
        end else begin
          cur = sb.pop_front();
          if (gc !== cur.code) begin
            errors++; $display("FAIL grant_order: code=%b required %b", gc, cur.code);
          end
          issue_chk = 1'b1;
        end
        last_win = g;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [1:0] code, input logic [71:0] pay);
    exp_t e;
    e.code = code; e.pay = pay;
    sb.push_back(e);
  endtask

  // Encoder model: called in the ISSUE cycle, stays busy for `hold` cycles,
  // then frees up and reports the done vector seen in that cycle.
  task automatic enc_cycle(input int hold, output logic [2:0] dn);
    free_inbound = 1'b0;
    repeat (hold) step();
    free_inbound = 1'b1;
    @(negedge clk);
    dn = {dat_done, tok_done, hs_done};
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hs_req = 0; tok_req = 0; dat_req = 0; free_inbound = 1'b1;
    hs_pid = '0; tok_bits = '0; dat_bits = '0;
    step(); step();
    @(negedge clk);
    checks++; if (pkt_type !== 2'b00) begin errors++; $display("FAIL rst_pkt: %b required 00", pkt_type); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b required 0", busy); end
    checks++; if (data !== 72'd0 || token !== 19'd0 || hshake !== 8'd0) begin
      errors++; $display("FAIL rst_payload: %h %h %h required 0", data, token, hshake); end
    checks++; if ({hs_gnt, tok_gnt, dat_gnt, hs_done, tok_done, dat_done} !== 6'd0) begin
      errors++; $display("FAIL rst_strobes: %b required 0", {hs_gnt, tok_gnt, dat_gnt, hs_done, tok_done, dat_done}); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_token();
    logic [2:0] dn;
    tok_bits = 19'h1ABCD; tok_req = 1'b1; free_inbound = 1'b1;
    push(2'b01, {53'd0, 19'h1ABCD});
    @(negedge clk);
    checks++; if (tok_gnt !== 1'b1) begin errors++; $display("FAIL single_gnt: %b required 1", tok_gnt); end
    step();
    tok_req = 1'b0;
    @(negedge clk);
    checks++; if (pkt_type !== 2'b01 || token !== 19'h1ABCD) begin
      errors++; $display("FAIL single_issue: %b %h required 01 1abcd", pkt_type, token); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: %b required 1", busy); end
    enc_cycle(2, dn);
    checks++; if (dn !== M_TOK) begin errors++; $display("FAIL single_done: %b required %b", dn, M_TOK); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b required 0", busy); end
    checks++; if (token !== 19'h1ABCD) begin errors++; $display("FAIL single_hold: %h required 1abcd", token); end
    step();
  endtask

  task automatic test_all_three();
    logic [2:0] exp_m [3];
    logic [2:0] dn, g;
    exp_m[0] = M_HS; exp_m[1] = M_TOK; exp_m[2] = M_DAT;
    hs_pid = 8'hC3; tok_bits = TOKV; dat_bits = DATV;
    hs_req = 1'b1; tok_req = 1'b1; dat_req = 1'b1; free_inbound = 1'b1;
    push(2'b10, {64'd0, 8'hC3}); push(2'b01, {53'd0, TOKV}); push(2'b11, DATV);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      g = {dat_gnt, tok_gnt, hs_gnt};
      checks++; if (g !== exp_m[i]) begin errors++; $display("FAIL all3_gnt%0d: %b required %b", i, g, exp_m[i]); end
      step();
      if (g[0]) hs_req = 1'b0;
      if (g[1]) tok_req = 1'b0;
      if (g[2]) dat_req = 1'b0;
      enc_cycle(1 + i, dn);
      checks++; if (dn !== exp_m[i]) begin errors++; $display("FAIL all3_done%0d: %b required %b", i, dn, exp_m[i]); end
    end
    @(negedge clk);
    checks++; if ({dat_gnt, tok_gnt, hs_gnt} !== 3'b000) begin
      errors++; $display("FAIL all3_extra: %b required 000", {dat_gnt, tok_gnt, hs_gnt}); end
    step();
  endtask

  task automatic test_free_hold();
    logic [2:0] dn;
    free_inbound = 1'b0; dat_bits = 72'h11_2233_4455_6677_8899; dat_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (dat_gnt !== 1'b0 || pkt_type !== 2'b00) begin
        errors++; $display("FAIL hold_nogrant%0d: gnt=%b pkt=%b required 0 00", i, dat_gnt, pkt_type); end
      step();
    end
    free_inbound = 1'b1;
    push(2'b11, 72'h11_2233_4455_6677_8899);
    @(negedge clk);
    checks++; if (dat_gnt !== 1'b1) begin errors++; $display("FAIL hold_release: %b required 1", dat_gnt); end
    step();
    dat_req = 1'b0;
    enc_cycle(1, dn);
    checks++; if (dn !== M_DAT) begin errors++; $display("FAIL hold_done: %b required %b", dn, M_DAT); end
  endtask

  task automatic test_starve();
    logic [2:0] exp_m [6];
    logic [2:0] dn, g;
    for (int i = 0; i < 6; i++) exp_m[i] = M_TOK;
`ifdef TX_ARB_STARVE_EN
    exp_m[4] = M_DAT;
`endif
    tok_bits = TOKV; dat_bits = DATV;
    for (int i = 0; i < 6; i++) begin
      if (exp_m[i] == M_TOK) push(2'b01, {53'd0, TOKV});
      else                   push(2'b11, DATV);
    end
    tok_req = 1'b1; dat_req = 1'b1; free_inbound = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      g = {dat_gnt, tok_gnt, hs_gnt};
      checks++; if (g !== exp_m[i]) begin errors++; $display("FAIL starve_gnt%0d: %b required %b", i, g, exp_m[i]); end
      step();
`ifdef TX_ARB_STARVE_EN
      if (i == 3) begin
        checks++; if (u_dut.starve_cnt_q !== 3'd4) begin
          errors++; $display("FAIL starve_sat: cnt=%0d required 4", u_dut.starve_cnt_q); end
      end
      if (i == 4) begin
        checks++; if (u_dut.starve_cnt_q !== 3'd0) begin
          errors++; $display("FAIL starve_clr: cnt=%0d required 0", u_dut.starve_cnt_q); end
      end
`endif
      if (i == 5) begin tok_req = 1'b0; dat_req = 1'b0; end
      enc_cycle(1, dn);
      checks++; if (dn !== exp_m[i]) begin errors++; $display("FAIL starve_done%0d: %b required %b", i, dn, exp_m[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] dn;
    hs_pid = 8'hA5; hs_req = 1'b1; free_inbound = 1'b1;
    push(2'b10, {64'd0, 8'hA5});
    @(negedge clk);
    checks++; if (hs_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt: %b required 1", hs_gnt); end
    step();
    hs_req = 1'b0; free_inbound = 1'b0;
    step(); step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: %b required 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || pkt_type !== 2'b00) begin
      errors++; $display("FAIL mid_rst_state: busy=%b pkt=%b required 0 00", busy, pkt_type); end
    checks++; if (hshake !== 8'd0 || token !== 19'd0 || data !== 72'd0) begin
      errors++; $display("FAIL mid_rst_payload: %h %h %h required 0", hshake, token, data); end
    free_inbound = 1'b1;
    @(negedge clk);
    checks++; if ({hs_done, tok_done, dat_done} !== 3'b000) begin
      errors++; $display("FAIL mid_no_done: %b required 000", {hs_done, tok_done, dat_done}); end
    step();
    rst_n = 1'b1;
    step();
    tok_bits = 19'h0F00F; tok_req = 1'b1;
    push(2'b01, {53'd0, 19'h0F00F});
    @(negedge clk);
    checks++; if (tok_gnt !== 1'b1) begin errors++; $display("FAIL mid_regrant: %b required 1", tok_gnt); end
    step();
    tok_req = 1'b0;
    enc_cycle(1, dn);
    checks++; if (dn !== M_TOK) begin errors++; $display("FAIL mid_done: %b required %b", dn, M_TOK); end
  endtask

  initial begin
    test_reset();
    test_single_token();
    test_all_three();
    test_free_hold();
    test_starve();
    test_reset_mid();
    repeat (2) step();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d entries required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_pkt_arbiter.md
# tx_pkt_arbiter

Shares the bit-stuff/serial packet encoder among three packet sources: the handshake responder, the token generator and the data sender. It arbitrates among pending requests, latches the winner's payload and presents it to the encoder as a one-cycle packet-type strobe. It then holds off further grants until the encoder reports free again, and returns a completion pulse to the winning source. It sits between the protocol FSM sources and the encoder's `pkt_type`/`free_inbound` handshake.

## Interface
Parameters:
- `DATA_STARVE_LIMIT`, default 4: the number of consecutive token wins over a pending data request after which data outranks token.

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `hs_req`  in  1  handshake source request; held high with `hs_pid` stable until `hs_gnt`
- `hs_pid`  in  8  handshake payload
- `hs_gnt` / `hs_done`  out  1 each  grant pulse / completion pulse
- `tok_req`  in  1  token request
- `tok_bits`  in  19  token payload
- `tok_gnt` / `tok_done`  out  1 each  grant pulse / completion pulse
- `dat_req`  in  1  data request
- `dat_bits`  in  72  data payload
- `dat_gnt` / `dat_done`  out  1 each  grant pulse / completion pulse
- `free_inbound`  in  1  encoder ready to accept a packet
- `pkt_type`  out  2  to encoder: 00 none, 01 token, 10 handshake, 11 data
- `data` / `token` / `hshake`  out  72 / 19 / 8  latched payloads to encoder
- `busy`  out  1  high in every state except IDLE

## Operation
States are IDLE, ISSUE and BUSY.

IDLE:
- Requests are sampled only in IDLE, and only when `free_inbound`=1.
- The winner is chosen by priority: handshake, then token, then data. The starvation override (see Configuration) can swap token and data.
- The winner's `*_gnt` is asserted combinationally for that single cycle. The winner's payload is latched into its output register at the clock edge, and the state moves to ISSUE.
- The payload registers of the non-winners keep their values.

ISSUE (exactly one cycle):
- `pkt_type` carries the winner's code; it is 00 in every other state.
- Next state is BUSY, unconditionally.

BUSY:
- The block waits for `free_inbound`=1.
- In the cycle `free_inbound`=1 is seen, the winner's `*_done` pulses combinationally and the state returns to IDLE.

Boundary conditions:
- Simultaneous requests: exactly one grant per arbitration. Losing requests stay pending and are re-evaluated in the next IDLE cycle.
- A request that drops before it is granted is simply not served.
- Re-asserting `req` during BUSY has no effect until IDLE.
- `free_inbound`=0 in IDLE: no grant, whatever the request state.
- Reset asserted mid-packet: the block returns to IDLE immediately, with no `done` pulse. The encoder shares `rst_n`.
- Reset values:
  - state IDLE
  - `pkt_type` 00
  - `data`, `token`, `hshake` 0
  - all `gnt`/`done` outputs 0
  - `busy` 0
  - starvation counter 0

## Timing
- A request seen in IDLE at cycle N produces `gnt` at N and `pkt_type` at N+1. BUSY starts at N+2.
- `done` pulses in the cycle the encoder's `free_inbound` returns high. The earliest next grant is the following cycle, and its `pkt_type` appears one cycle after that.
- Payload outputs stay stable from the ISSUE cycle until the next grant.
- `gnt` and `done` are each exactly one cycle wide, and at most one of each is asserted per cycle.

## Configuration
Macro `TX_ARB_STARVE_EN`.

When defined:
- A saturating counter, width $clog2(DATA_STARVE_LIMIT+1), increments when token wins while `dat_req`=1.
- The counter clears to 0 on any data grant. Handshake grants leave it unchanged.
- While the counter equals `DATA_STARVE_LIMIT`, data beats token. Handshake still beats both.

When undefined:
- Strict fixed priority applies.
- There is no counter, and `DATA_STARVE_LIMIT` is ignored.

## Structure
Shared package `usb_tx_pkg` holds:
- the packet codes (PKT_NONE=00, PKT_TOKEN=01, PKT_HSHAKE=10, PKT_DATA=11);
- the payload width constants (72, 19, 8);
- the `tx_arb_state_t` enum.

Sub-module `tx_arb_pick`: combinational winner select. It takes the three requests and the starvation flag, and outputs a one-hot winner.

## Test plan
- `tok_req` with `tok_bits`=19'h1ABCD, encoder idle → `tok_gnt` at N, `pkt_type`=01 and `token`=19'h1ABCD at N+1, `tok_done` when `free_inbound` returns, `busy` 0 the cycle after.
- `hs_req`, `tok_req` and `dat_req` all asserted in the same cycle → served in the order handshake, token, data. Exactly three `gnt` pulses and three `done` pulses, with no overlap.
- `free_inbound` held 0 while `dat_req`=1 → no `dat_gnt` and `pkt_type` stays 00. Releasing it gives `dat_gnt` the same cycle.
- With `TX_ARB_STARVE_EN` and `DATA_STARVE_LIMIT`=4, `tok_req` and `dat_req` held high continuously → four token packets, then one data packet, then the counter reads 0.
- Same stimulus with the macro undefined → data is never granted while `tok_req` stays high.
- `rst_n` low during BUSY → all outputs return to reset values at once, no `done` pulse, and a fresh grant follows after release.
